// File: rtl/load_store_queue.sv
// In-order load/store queue feeding the data-memory controller; issues one op per cycle, oldest first.
// Optional issue counters (perf_loads/perf_stores) are compiled in when LSQ_PERF_EN is defined.
module load_store_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic                    enq_is_store,
    input  logic [31:0]             enq_addr,
    input  logic [31:0]             enq_data,
    input  logic [TAG_W-1:0]        enq_tag,
    input  logic                    flush,
    output logic                    mem_write,
    output logic                    mem_read,
    output logic [31:0]             mem_address,
    output logic [31:0]             mem_write_data,
    input  logic [31:0]             mem_read_data,
    output logic                    resp_valid,
    output logic [TAG_W-1:0]        resp_tag,
    output logic [31:0]             resp_data,
    output logic [$clog2(DEPTH):0]  count
`ifdef LSQ_PERF_EN
    ,
    output logic [31:0]             perf_loads,
    output logic [31:0]             perf_stores
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             is_store;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pend_valid_q, pend_valid_d;
    logic [TAG_W-1:0]   pend_tag_q, pend_tag_d;

    entry_t             head_entry;
    logic               issue;
    logic               enq_fire;

    // Issue/enqueue decisions and the combinational memory request from the head entry.
    always_comb begin
        head_entry     = mem_q[head_q];
        issue          = (count_q != '0) && !flush;
        enq_ready      = count_q < CNT_W'(DEPTH);
        enq_fire       = enq_valid && enq_ready && !flush;

        mem_write      = 1'b0;
        mem_read       = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (issue) begin
            mem_write      = head_entry.is_store;
            mem_read       = !head_entry.is_store;
            mem_address    = head_entry.addr;
            mem_write_data = head_entry.is_store ? head_entry.data : 32'h0;
        end
    end

    // Next-state for pointers, occupancy and the pending load response.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        pend_valid_d = 1'b0;
        pend_tag_d   = pend_tag_q;

        if (flush) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (issue) begin
                head_d = PTR_W'(head_q + 1'b1);
                if (!head_entry.is_store) begin
                    pend_valid_d = 1'b1;
                    pend_tag_d   = head_entry.tag;
                end
            end
            if (enq_fire) begin
                tail_d = PTR_W'(tail_q + 1'b1);
            end
            count_d = CNT_W'(count_q + CNT_W'(enq_fire) - CNT_W'(issue));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_tag_q   <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            pend_valid_q <= pend_valid_d;
            pend_tag_q   <= pend_tag_d;
        end
    end

    // Queue storage is intentionally left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_q[tail_q] <= '{is_store: enq_is_store, addr: enq_addr,
                               data: enq_data, tag: enq_tag};
        end
    end

    assign count      = count_q;
    assign resp_valid = pend_valid_q;
    assign resp_tag   = pend_tag_q;
    // Data only passes through while a response is live so idle/reset outputs read zero.
    assign resp_data  = pend_valid_q ? mem_read_data : 32'h0;

`ifdef LSQ_PERF_EN
    logic [31:0] perf_loads_q, perf_stores_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
        end else if (issue) begin
            if (head_entry.is_store) begin
                perf_stores_q <= perf_stores_q + 32'd1;
            end else begin
                perf_loads_q  <= perf_loads_q + 32'd1;
            end
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
`endif

endmodule

// File: tb/tb_load_store_queue.sv
// Self-checking bench for load_store_queue: directed scenarios then random traffic vs. a queue-level model.
module tb_load_store_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct {
        bit               st;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } op_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              enq_valid;
    logic              enq_ready;
    logic              enq_is_store;
    logic [31:0]       enq_addr;
    logic [31:0]       enq_data;
    logic [TAG_W-1:0]  enq_tag;
    logic              flush;
    logic              mem_write;
    logic              mem_read;
    logic [31:0]       mem_address;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;
    logic              resp_valid;
    logic [TAG_W-1:0]  resp_tag;
    logic [31:0]       resp_data;
    logic [CNT_W-1:0]  count;
`ifdef LSQ_PERF_EN
    logic [31:0]       perf_loads;
    logic [31:0]       perf_stores;
`endif

    load_store_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .enq_valid      (enq_valid),
        .enq_ready      (enq_ready),
        .enq_is_store   (enq_is_store),
        .enq_addr       (enq_addr),
        .enq_data       (enq_data),
        .enq_tag        (enq_tag),
        .flush          (flush),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .resp_valid     (resp_valid),
        .resp_tag       (resp_tag),
        .resp_data      (resp_data),
        .count          (count)
`ifdef LSQ_PERF_EN
        ,
        .perf_loads     (perf_loads),
        .perf_stores    (perf_stores)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int unsigned idx);
        return 32'hA5A5_0000 ^ 32'(idx * 32'h0001_0101);
    endfunction

    // Environment memory: writes land at the edge, reads return one cycle later.
    logic [31:0] env_mem [64];
    bit          env_wr  [64];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (mem_write) begin
            env_mem[mem_address[7:2]] <= mem_write_data;
            env_wr[mem_address[7:2]]  <= 1'b1;
        end
        if (mem_read) begin
            rd_q <= env_wr[mem_address[7:2]] ? env_mem[mem_address[7:2]]
                                             : init_word(int'(mem_address[7:2]));
        end
    end
    assign mem_read_data = rd_q;

    // Reference model state.
    op_t              mq[$];
    bit               m_pend;
    logic [TAG_W-1:0] m_ptag;
    logic [31:0]      m_pdata;
    logic [31:0]      m_mem [64];
    int unsigned      m_loads;
    int unsigned      m_stores;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend   = 1'b0;
        m_ptag   = '0;
        m_loads  = 0;
        m_stores = 0;
    endtask

    // One clock cycle: drive inputs, check all outputs against the model, then advance the model.
    task automatic step(input bit v, input bit st, input logic [31:0] a,
                        input logic [31:0] d, input logic [TAG_W-1:0] t, input bit fl);
        bit  iss;
        bit  acc;
        op_t o;
        @(negedge clk);
        enq_valid    = v;
        enq_is_store = st;
        enq_addr     = a;
        enq_data     = d;
        enq_tag      = t;
        flush        = fl;
        #1;
        iss = !fl && (mq.size() > 0);
        chk("count",          32'(count),         32'(mq.size()));
        chk("enq_ready",      32'(enq_ready),     32'(mq.size() < DEPTH));
        chk("mem_write",      32'(mem_write),     32'(iss ? mq[0].st : 1'b0));
        chk("mem_read",       32'(mem_read),      32'(iss ? !mq[0].st : 1'b0));
        chk("mem_address",    mem_address,        iss ? mq[0].addr : 32'h0);
        chk("mem_write_data", mem_write_data,     (iss && mq[0].st) ? mq[0].data : 32'h0);
        chk("resp_valid",     32'(resp_valid),    32'(m_pend));
        if (m_pend) begin
            chk("resp_tag",  32'(resp_tag), 32'(m_ptag));
            chk("resp_data", resp_data,     m_pdata);
        end
`ifdef LSQ_PERF_EN
        chk("perf_loads",  perf_loads,  m_loads);
        chk("perf_stores", perf_stores, m_stores);
`endif
        acc = v && (mq.size() < DEPTH) && !fl;
        m_pend = 1'b0;
        if (iss) begin
            o = mq.pop_front();
            if (o.st) begin
                m_mem[o.addr[7:2]] = o.data;
                m_stores++;
            end else begin
                m_pdata = m_mem[o.addr[7:2]];
                m_ptag  = o.tag;
                m_pend  = 1'b1;
                m_loads++;
            end
        end
        if (fl) begin
            mq.delete();
            m_pend = 1'b0;
        end
        if (acc) mq.push_back('{st: st, addr: a, data: d, tag: t});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, '0, 1'b0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_count",      32'(count),      32'h0);
        chk("rst_enq_ready",  32'(enq_ready),  32'h1);
        chk("rst_mem_write",  32'(mem_write),  32'h0);
        chk("rst_mem_read",   32'(mem_read),   32'h0);
        chk("rst_mem_addr",   mem_address,     32'h0);
        chk("rst_mem_wdata",  mem_write_data,  32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_tag",   32'(resp_tag),   32'h0);
        chk("rst_resp_data",  resp_data,       32'h0);
`ifdef LSQ_PERF_EN
        chk("rst_perf_loads",  perf_loads,  32'h0);
        chk("rst_perf_stores", perf_stores, 32'h0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);
        model_reset();
        reset        = 1'b1;
        enq_valid    = 1'b0;
        enq_is_store = 1'b0;
        enq_addr     = '0;
        enq_data     = '0;
        enq_tag      = '0;
        flush        = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        reset = 1'b0;

        // Store then load to the same word: load must return the stored value.
        step(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, '0, 1'b0);
        step(1'b1, 1'b0, 32'h10, 32'h0, 5'd7, 1'b0);
        idle(3);

        // Back-to-back enqueues, including a fifth request.
        for (int i = 0; i < 5; i++)
            step(1'b1, i[0], 32'h20 + 32'(i * 4), 32'h1000 + 32'(i), TAG_W'(i + 16), 1'b0);
        idle(2);

        // Ten consecutive loads, tags 0..9, wrapping the pointers.
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 32'h40 + 32'(i * 4), 32'h0, TAG_W'(i), 1'b0);
        idle(3);

        // Flush with a queued entry, a pending load and a same-cycle enqueue.
        step(1'b1, 1'b0, 32'h80, 32'h0, 5'd3, 1'b0);
        step(1'b1, 1'b1, 32'h84, 32'hCAFE0001, 5'd4, 1'b0);
        step(1'b1, 1'b1, 32'h88, 32'hCAFE0002, 5'd5, 1'b1);
        idle(3);

        // Asynchronous reset mid-stream with a load pending.
        step(1'b1, 1'b0, 32'h0C, 32'h0, 5'd9, 1'b0);
        step(1'b1, 1'b0, 32'h14, 32'h0, 5'd10, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, '0, 1'b0);
        @(negedge clk);
        enq_valid = 1'b0;
        flush     = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk_reset_outputs();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b1, 32'h30, 32'h12345678, '0, 1'b0);
        step(1'b1, 1'b0, 32'h30, 32'h0, 5'd21, 1'b0);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom % 10) < 7, $urandom % 2 == 0, $urandom, $urandom,
                 TAG_W'($urandom), ($urandom % 20) == 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
